// File: rtl/pcm_frame_assembler_pkg.sv
// Shared audio definitions: byte-collector states and the 4-byte stereo frame layout.
// The FIFO and DAC stages import the same lane positions.
package pcm_frame_assembler_pkg;

   typedef enum logic [1:0] {
      WAIT_B0 = 2'd0,
      WAIT_B1 = 2'd1,
      WAIT_B2 = 2'd2,
      WAIT_B3 = 2'd3
   } pcm_state_t;

   localparam int FRAME_BYTES = 4;
   localparam int FRAME_BITS  = 32;
   localparam int COUNT_BITS  = 16;

   // Little-endian samples: left = {B1,B0}, right = {B3,B2}.
   localparam int B0_LSB = 16;
   localparam int B1_LSB = 24;
   localparam int B2_LSB = 0;
   localparam int B3_LSB = 8;

   function automatic logic [FRAME_BITS-1:0] assemble_frame(
      input logic [7:0] b0,
      input logic [7:0] b1,
      input logic [7:0] b2,
      input logic [7:0] b3
   );
      logic [FRAME_BITS-1:0] f;
      f = '0;
      f[B0_LSB +: 8] = b0;
      f[B1_LSB +: 8] = b1;
      f[B2_LSB +: 8] = b2;
      f[B3_LSB +: 8] = b3;
      return f;
   endfunction

   function automatic logic [COUNT_BITS-1:0] sat_inc(input logic [COUNT_BITS-1:0] v);
      return (v == {COUNT_BITS{1'b1}}) ? v : v + COUNT_BITS'(1);
   endfunction

endpackage

// File: rtl/pcm_frame_assembler_if.sv
// Byte-in / frame-out bundle of the PCM frame assembler, including FIFO status and counters.
// Handshake: rx_data is taken on any clk edge where rx_valid is 1 (no back-pressure);
// wr_data is valid only on the single cycle wr_en is 1 and is held otherwise.
interface pcm_frame_assembler_if #(
   parameter int FILL_BITS = 12
);
   import pcm_frame_assembler_pkg::*;

   logic [7:0]           rx_data;
   logic                 rx_valid;
   logic                 fifo_full;
   logic [FILL_BITS-1:0] fifo_fill;
   logic [31:0]          wr_data;
   logic                 wr_en;
   logic                 cts;
   logic [15:0]          drop_count;
   logic [15:0]          resync_count;
   pcm_state_t           state_dbg;

   modport master (
      output rx_data, rx_valid, fifo_full, fifo_fill,
      input  wr_data, wr_en, cts, drop_count, resync_count, state_dbg
   );

   modport slave (
      input  rx_data, rx_valid, fifo_full, fifo_fill,
      output wr_data, wr_en, cts, drop_count, resync_count, state_dbg
   );

endinterface

// File: rtl/pcm_frame_assembler_hysteresis_flag.sv
// Registered flag with hysteresis: cleared at/above HIGH_MARK, set at/below LOW_MARK,
// held in between; force_clear overrides. Usable for CTS or DSR-style almost-full flags.
module hysteresis_flag #(
   parameter int   WIDTH     = 12,
   parameter int   LOW_MARK  = 1228,
   parameter int   HIGH_MARK = 2048,
   parameter logic RESET_VAL = 1'b1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] level,
   input  logic             force_clear,
   output logic             flag
);

   localparam logic [WIDTH-1:0] LOW_LVL  = WIDTH'(LOW_MARK);
   localparam logic [WIDTH-1:0] HIGH_LVL = WIDTH'(HIGH_MARK);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         flag <= RESET_VAL;
      end else if (force_clear) begin
         flag <= 1'b0;
      end else if (level >= HIGH_LVL) begin
         flag <= 1'b0;
      end else if (level <= LOW_LVL) begin
         flag <= 1'b1;
      end
   end

endmodule

// File: rtl/pcm_frame_assembler.sv
// Collects four UART bytes into one 32-bit stereo frame and writes it to the downstream FIFO,
// with mid-frame gap resync, drop/resync counters and hysteretic clear-to-send.
module pcm_frame_assembler
   import pcm_frame_assembler_pkg::*;
#(
   parameter int CLK_FREQ    = 12_000_000,
   parameter int GAP_TIMEOUT = 1200,
   parameter int FILL_BITS   = 12,
   parameter int LOW_MARK    = 1228,
   parameter int HIGH_MARK   = 2048
) (
   input logic                  clk,
   input logic                  reset_n,
   pcm_frame_assembler_if.slave bus
);

   localparam int GAP_W = $clog2(GAP_TIMEOUT + 1);
   localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(GAP_TIMEOUT);

   if (CLK_FREQ < 1 || GAP_TIMEOUT < 2 || HIGH_MARK <= LOW_MARK) begin : g_bad_params
      $error("pcm_frame_assembler: illegal parameter combination");
   end

   pcm_state_t            state_q, state_d;
   logic [GAP_W-1:0]      gap_q, gap_d, gap_inc;
   logic [7:0]            b0_q, b0_d, b1_q, b1_d, b2_q, b2_d;
   logic [FRAME_BITS-1:0] wr_data_q, wr_data_d;
   logic                  wr_en_q, wr_en_d;
   logic [COUNT_BITS-1:0] drop_q, drop_d, resync_q, resync_d;
   logic                  cts_w;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= WAIT_B0;
         gap_q     <= '0;
         b0_q      <= '0;
         b1_q      <= '0;
         b2_q      <= '0;
         wr_data_q <= '0;
         wr_en_q   <= 1'b0;
         drop_q    <= '0;
         resync_q  <= '0;
      end else begin
         state_q   <= state_d;
         gap_q     <= gap_d;
         b0_q      <= b0_d;
         b1_q      <= b1_d;
         b2_q      <= b2_d;
         wr_data_q <= wr_data_d;
         wr_en_q   <= wr_en_d;
         drop_q    <= drop_d;
         resync_q  <= resync_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      gap_d     = gap_q;
      gap_inc   = gap_q + GAP_W'(1);
      b0_d      = b0_q;
      b1_d      = b1_q;
      b2_d      = b2_q;
      wr_data_d = wr_data_q;
      wr_en_d   = 1'b0;
      drop_d    = drop_q;
      resync_d  = resync_q;

      // A byte arriving on the timeout cycle wins: it is accepted and the gap restarts.
      if (bus.rx_valid) begin
         gap_d = '0;
         case (state_q)
            WAIT_B0: begin
               b0_d    = bus.rx_data;
               state_d = WAIT_B1;
            end
            WAIT_B1: begin
               b1_d    = bus.rx_data;
               state_d = WAIT_B2;
            end
            WAIT_B2: begin
               b2_d    = bus.rx_data;
               state_d = WAIT_B3;
            end
            WAIT_B3: begin
               state_d = WAIT_B0;
               if (!bus.fifo_full) begin
                  wr_en_d   = 1'b1;
                  wr_data_d = assemble_frame(b0_q, b1_q, b2_q, bus.rx_data);
               end else begin
                  drop_d = sat_inc(drop_q);
               end
            end
            default: state_d = WAIT_B0;
         endcase
      end else if (state_q != WAIT_B0) begin
         if (gap_inc == GAP_LIMIT) begin
            state_d  = WAIT_B0;
            gap_d    = '0;
            b0_d     = '0;
            b1_d     = '0;
            b2_d     = '0;
            resync_d = sat_inc(resync_q);
         end else begin
            gap_d = gap_inc;
         end
      end
   end

   hysteresis_flag #(
      .WIDTH     (FILL_BITS),
      .LOW_MARK  (LOW_MARK),
      .HIGH_MARK (HIGH_MARK),
      .RESET_VAL (1'b1)
   ) u_cts_flag (
      .clk         (clk),
      .reset_n     (reset_n),
      .level       (bus.fifo_fill),
      .force_clear (bus.fifo_full),
      .flag        (cts_w)
   );

   assign bus.wr_data      = wr_data_q;
   assign bus.wr_en        = wr_en_q;
   assign bus.cts          = cts_w;
   assign bus.drop_count   = drop_q;
   assign bus.resync_count = resync_q;
   assign bus.state_dbg    = state_q;

endmodule

// File: tb/tb_pcm_frame_assembler.sv
// Directed bench for pcm_frame_assembler: frame and CTS vector tables plus
// hand-written drop, gap-timeout and mid-frame reset sequences.
module tb_pcm_frame_assembler;
   import pcm_frame_assembler_pkg::*;

   localparam int GT = 8;

   typedef struct {
      logic [7:0]  b0;
      logic [7:0]  b1;
      logic [7:0]  b2;
      logic [7:0]  b3;
      logic [31:0] exp_data;
   } frame_vec_t;

   typedef struct {
      logic [11:0] fill;
      logic        full;
      logic        exp_cts;
   } cts_vec_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   exp_drop = 0;
   int   exp_resync = 0;
   logic [31:0] last_wr = '0;
   logic [31:0] exp_q[$];

   frame_vec_t frames[5];
   cts_vec_t   cts_vecs[12];

   always #5 clk = ~clk;

   pcm_frame_assembler_if #(.FILL_BITS(12)) bus ();

   pcm_frame_assembler #(
      .CLK_FREQ    (12_000_000),
      .GAP_TIMEOUT (GT),
      .FILL_BITS   (12),
      .LOW_MARK    (1228),
      .HIGH_MARK   (2048)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Called at a negedge; returns at the next negedge with rx_valid low again.
   task automatic send_byte(input logic [7:0] b, input logic full);
      bus.rx_data   = b;
      bus.rx_valid  = 1'b1;
      bus.fifo_full = full;
      @(negedge clk);
      bus.rx_valid  = 1'b0;
      bus.fifo_full = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                             input logic [7:0] b3, input logic full, input logic [31:0] exp);
      send_byte(b0, 1'b0);
      send_byte(b1, 1'b0);
      send_byte(b2, 1'b0);
      check("no_early_wr", 32'(bus.wr_en), 32'd0);
      if (!full) exp_q.push_back(exp);
      send_byte(b3, full);
      if (full) begin
         exp_drop++;
         check("drop_no_wr", 32'(bus.wr_en), 32'd0);
         check("drop_count", 32'(bus.drop_count), 32'(exp_drop));
         check("drop_data_held", bus.wr_data, last_wr);
      end else begin
         last_wr = exp;
         check("wr_en_pulse", 32'(bus.wr_en), 32'd1);
         check("wr_data", bus.wr_data, exp);
      end
      @(negedge clk);
      check("wr_en_single", 32'(bus.wr_en), 32'd0);
      check("data_hold", bus.wr_data, last_wr);
   endtask

   // Scoreboard: every write strobe must match the oldest expected frame.
   always @(negedge clk) begin
      if (reset_n && bus.wr_en) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_unexpected_wr: got 0x%0h expected no write", bus.wr_data);
         end else begin
            check("sb_frame", bus.wr_data, exp_q.pop_front());
         end
      end
   end

   initial begin
      frames[0] = '{8'h34, 8'h12, 8'h78, 8'h56, 32'h1234_5678};
      frames[1] = '{8'h00, 8'h00, 8'h00, 8'h00, 32'h0000_0000};
      frames[2] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 32'hFFFF_FFFF};
      frames[3] = '{8'h01, 8'h02, 8'h03, 8'h04, 32'h0201_0403};
      frames[4] = '{8'hAA, 8'h55, 8'h0F, 8'hF0, 32'h55AA_F00F};

      cts_vecs[0]  = '{12'd0,    1'b0, 1'b1};
      cts_vecs[1]  = '{12'd2048, 1'b0, 1'b0};
      cts_vecs[2]  = '{12'd1500, 1'b0, 1'b0};
      cts_vecs[3]  = '{12'd1228, 1'b0, 1'b1};
      cts_vecs[4]  = '{12'd1500, 1'b0, 1'b1};
      cts_vecs[5]  = '{12'd2047, 1'b0, 1'b1};
      cts_vecs[6]  = '{12'd4095, 1'b0, 1'b0};
      cts_vecs[7]  = '{12'd1229, 1'b0, 1'b0};
      cts_vecs[8]  = '{12'd0,    1'b0, 1'b1};
      cts_vecs[9]  = '{12'd0,    1'b1, 1'b0};
      cts_vecs[10] = '{12'd100,  1'b0, 1'b1};
      cts_vecs[11] = '{12'd1227, 1'b1, 1'b0};

      bus.rx_data   = '0;
      bus.rx_valid  = 1'b0;
      bus.fifo_full = 1'b0;
      bus.fifo_fill = '0;

      // Clock/reset
      repeat (2) @(negedge clk);
      check("rst_wr_en", 32'(bus.wr_en), 32'd0);
      check("rst_wr_data", bus.wr_data, 32'd0);
      check("rst_cts", 32'(bus.cts), 32'd1);
      check("rst_drop", 32'(bus.drop_count), 32'd0);
      check("rst_resync", 32'(bus.resync_count), 32'd0);
      check("rst_state", 32'(bus.state_dbg), 32'(WAIT_B0));
      reset_n = 1'b1;
      @(negedge clk);

      foreach (frames[i])
         send_frame(frames[i].b0, frames[i].b1, frames[i].b2, frames[i].b3, 1'b0, frames[i].exp_data);

      // FIFO full on the last byte drops the frame, the next one goes through.
      send_frame(8'h11, 8'h22, 8'h33, 8'h44, 1'b1, 32'h0);
      send_frame(8'h34, 8'h12, 8'h78, 8'h56, 1'b0, 32'h1234_5678);

      // Gap timeout after two bytes: one cycle short, then exactly at the limit.
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      repeat (GT - 1) @(negedge clk);
      check("gap_short_resync", 32'(bus.resync_count), 32'(exp_resync));
      check("gap_short_state", 32'(bus.state_dbg), 32'(WAIT_B2));
      @(negedge clk);
      exp_resync++;
      check("gap_resync", 32'(bus.resync_count), 32'(exp_resync));
      check("gap_state", 32'(bus.state_dbg), 32'(WAIT_B0));
      send_frame(8'h01, 8'h00, 8'h02, 8'h00, 1'b0, 32'h0001_0002);

      // Byte arriving on the timeout cycle is accepted instead of resyncing.
      send_byte(8'h9A, 1'b0);
      send_byte(8'hBC, 1'b0);
      repeat (GT - 1) @(negedge clk);
      send_byte(8'hDE, 1'b0);
      check("edge_resync", 32'(bus.resync_count), 32'(exp_resync));
      check("edge_state", 32'(bus.state_dbg), 32'(WAIT_B3));
      exp_q.push_back(32'hBC9A_F0DE);
      last_wr = 32'hBC9A_F0DE;
      send_byte(8'hF0, 1'b0);
      check("edge_wr_en", 32'(bus.wr_en), 32'd1);
      check("edge_wr_data", bus.wr_data, 32'hBC9A_F0DE);
      @(negedge clk);

      // An idle line in WAIT_B0 never resyncs.
      repeat (3 * GT) @(negedge clk);
      check("idle_resync", 32'(bus.resync_count), 32'(exp_resync));

      foreach (cts_vecs[i]) begin
         bus.fifo_fill = cts_vecs[i].fill;
         bus.fifo_full = cts_vecs[i].full;
         @(negedge clk);
         check($sformatf("cts_vec%0d", i), 32'(bus.cts), 32'(cts_vecs[i].exp_cts));
      end
      bus.fifo_full = 1'b0;
      bus.fifo_fill = 12'd3000;
      @(negedge clk);
      check("cts_high", 32'(bus.cts), 32'd0);

      // Reset mid-frame after three bytes.
      send_byte(8'h55, 1'b0);
      send_byte(8'h66, 1'b0);
      send_byte(8'h77, 1'b0);
      reset_n = 1'b0;
      #1;
      check("mid_rst_wr_en", 32'(bus.wr_en), 32'd0);
      check("mid_rst_wr_data", bus.wr_data, 32'd0);
      check("mid_rst_cts", 32'(bus.cts), 32'd1);
      check("mid_rst_drop", 32'(bus.drop_count), 32'd0);
      check("mid_rst_resync", 32'(bus.resync_count), 32'd0);
      check("mid_rst_state", 32'(bus.state_dbg), 32'(WAIT_B0));
      bus.fifo_fill = '0;
      @(negedge clk);
      reset_n = 1'b1;
      exp_drop = 0;
      exp_resync = 0;
      last_wr = '0;
      @(negedge clk);
      check("post_rst_no_wr", 32'(bus.wr_en), 32'd0);
      send_frame(8'h34, 8'h12, 8'h78, 8'h56, 1'b0, 32'h1234_5678);
      check("post_rst_drop", 32'(bus.drop_count), 32'(exp_drop));

      repeat (2) @(negedge clk);
      check("sb_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pcm_frame_assembler.md
PCM_FRAME_ASSEMBLER -- requirements
Module: pcm_frame_assembler

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 12_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter GAP_TIMEOUT, default 1200, idle clk cycles mid-frame before resync; minimum 2.
REQ-003 SHALL have parameter FILL_BITS, default 12, width of the FIFO fill input.
REQ-004 SHALL have parameter LOW_MARK, default 1228, fill at or below which the sender is released.
REQ-005 SHALL have parameter HIGH_MARK, default 2048, fill at or above which the sender is held; HIGH_MARK > LOW_MARK.
REQ-006 SHALL have port clk, input, 1, single clock; all logic in this domain.
REQ-007 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port rx_data, input, 8, received UART byte.
REQ-009 SHALL have port rx_valid, input, 1, one-cycle strobe qualifying rx_data.
REQ-010 SHALL have port fifo_full, input, 1, downstream FIFO full.
REQ-011 SHALL have port fifo_fill, input, FILL_BITS, downstream FIFO occupancy.
REQ-012 SHALL have port wr_data, output, 32, stereo frame: [31:16] left, [15:0] right.
REQ-013 SHALL have port wr_en, output, 1, one-cycle FIFO write strobe.
REQ-014 SHALL have port cts, output, 1, clear-to-send to host, 1 = send.
REQ-015 SHALL have port drop_count, output, 16, saturating count of frames discarded on fifo_full.
REQ-016 SHALL have port resync_count, output, 16, saturating count of gap-timeout aborts.

Function
REQ-017 SHALL implement states WAIT_B0, WAIT_B1, WAIT_B2, WAIT_B3, advancing one state per rx_valid, WAIT_B3 returning to WAIT_B0.
REQ-018 SHALL place bytes little-endian per channel: B0 -> [23:16], B1 -> [31:24], B2 -> [7:0], B3 -> [15:8].
REQ-019 SHALL, on rx_valid in WAIT_B3 with fifo_full low, drive wr_en high exactly one cycle later with the complete frame on wr_data.
REQ-020 SHALL, on rx_valid in WAIT_B3 with fifo_full high, not assert wr_en, increment drop_count (saturate at 0xFFFF), and return to WAIT_B0.
REQ-021 SHALL hold wr_data stable when wr_en is low; wr_en never asserted on two consecutive cycles.
REQ-022 SHALL run a gap counter cleared on every rx_valid and counting otherwise while state is not WAIT_B0.
REQ-023 SHALL, when the gap counter reaches GAP_TIMEOUT, return to WAIT_B0, discard partial bytes, and increment resync_count (saturating).
REQ-024 SHALL give rx_valid priority over timeout in the same cycle: the byte is accepted and the counter cleared.
REQ-025 SHALL not count the gap while in WAIT_B0; an idle line never increments resync_count.
REQ-026 SHALL register cts: clear when fifo_fill >= HIGH_MARK, set when fifo_fill <= LOW_MARK, otherwise hold (hysteresis).
REQ-027 SHALL clear cts whenever fifo_full is high, regardless of fifo_fill.

Reset
REQ-028 SHALL, on reset_n low, asynchronously set state WAIT_B0, wr_en 0, wr_data 0, gap counter 0, drop_count 0, resync_count 0, cts 1.
REQ-029 SHALL, on reset asserted mid-frame, discard the partial frame; first rx_valid after release is B0.
REQ-030 SHALL deassert reset synchronously to clk externally; this block adds no synchronizer.

Structure
REQ-031 SHALL keep state encodings and the 4-byte frame layout constants in the shared audio package, reused by the FIFO and DAC stages.
REQ-032 SHALL instantiate one sub-module, hysteresis_flag, implementing REQ-026/REQ-027, reusable for DSR-style almost-full flags.
REQ-033 SHALL size the gap counter as $clog2(GAP_TIMEOUT+1) bits.

Verification
REQ-034 SHALL test bytes 0x34,0x12,0x78,0x56 -> one wr_en pulse, wr_data = 0x12345678.
REQ-035 SHALL test fifo_full=1 during the fourth byte -> no wr_en, drop_count = 1, next four bytes write normally.
REQ-036 SHALL test two bytes then GAP_TIMEOUT idle cycles -> resync_count = 1, next four bytes 0x01,0x00,0x02,0x00 -> wr_data = 0x00010002.
REQ-037 SHALL test fifo_fill ramp 0 -> 2048 -> 1500 -> 1228 -> cts 1, 0 at 2048, 0 at 1500, 1 at 1228.
REQ-038 SHALL test reset_n pulsed low after three bytes -> all outputs at reset values, no wr_en, next frame assembled from B0.
REQ-039 SHALL test rx_valid on the exact cycle the gap counter reaches GAP_TIMEOUT -> byte accepted, resync_count unchanged.
